// File: rtl/rx_pkg.sv
// Shared types and constants for the CRC network link receive path.
package rx_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } rx_state_t;

    // CRC-16-CCITT: MSB-first, no reflection, no final XOR.
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Field layout of the 136-bit packet (bit 135 is first on the line).
    localparam int SYNC_MSB = 135;
    localparam int SYNC_LSB = 128;
    localparam int MODE_MSB = 127;
    localparam int MODE_LSB = 120;
    localparam int DATA_MSB = 119;
    localparam int DATA_LSB = 16;
    localparam int CRC_MSB  = 15;
    localparam int CRC_LSB  = 0;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/rx_crc16_serial.sv
// Bit-serial CRC-16 engine, one message bit per enabled clock.
// Shared with the transmitter so both ends compute the same checksum.
module rx_crc16_serial
    import rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic feedback;

    assign feedback = crc[15] ^ bit_in;

    // Shift register with polynomial feedback; clear has priority over a bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (bit_en) begin
            crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/rx_receiver.sv
// Serial receive stage: synchronises rx_line, deserialises one framed
// packet, checks sync byte and CRC-16, and presents the packet with a
// one-cycle rx_valid strobe plus error flags held until the next strobe.
// The field index constants in rx_pkg assume PKT_BITS = 136.
module rx_receiver
    import rx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 50,
    parameter int         PKT_BITS     = 136,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_line,
    output logic [PKT_BITS-1:0] rx_packet,
    output logic                rx_valid,
    output logic                crc_error,
    output logic                sync_error,
    output logic                frame_error,
    output logic                busy
);

    localparam int            TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF      = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    LAST_BIT  = 8'(PKT_BITS - 1);
    // CRC covers everything after the sync byte and before the CRC field.
    localparam logic [7:0]    CRC_FIRST = 8'd8;
    localparam logic [7:0]    CRC_LAST  = 8'(PKT_BITS - 17);

    rx_state_t           state;
    rx_state_t           state_next;
    logic                sync_q1;
    logic                line;
    logic                line_d;
    logic [TW-1:0]       timer;
    logic [7:0]          bit_cnt;
    logic [PKT_BITS-1:0] shreg;
    logic [15:0]         crc_value;
    logic                sample;
    logic                crc_clear;
    logic                crc_en;
    logic                shift_en;
    logic                load_out;

    assign sample = (timer == HALF);
    assign busy   = (state != IDLE);

    // Two-flop synchroniser plus one delayed copy for falling-edge detect.
    // All three idle high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            line    <= 1'b1;
            line_d  <= 1'b1;
        end else begin
            sync_q1 <= rx_line;
            line    <= sync_q1;
            line_d  <= line;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes.
    // A stuck-low line after a bad stop bit leaves line_d low, so no new
    // falling edge is seen until the line has gone high again.
    always_comb begin
        state_next = state;
        crc_clear  = 1'b0;
        crc_en     = 1'b0;
        shift_en   = 1'b0;
        load_out   = 1'b0;
        case (state)
            IDLE: begin
                if (line_d && !line) begin
                    state_next = START;
                    crc_clear  = 1'b1;
                end
            end
            START: begin
                if (sample) begin
                    state_next = line ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    shift_en = 1'b1;
                    crc_en   = (bit_cnt >= CRC_FIRST) && (bit_cnt <= CRC_LAST);
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (sample) begin
                    load_out   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bit timer: held at zero while idle, so the start-bit sample lands
    // mid-bit and free-running wrap keeps every later sample mid-bit too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state == IDLE) begin
            timer <= '0;
        end else if (timer == LAST_TICK) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Bit index within the payload; only meaningful in DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (state != DATA) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Deserialiser: first line bit ends up at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {shreg[PKT_BITS-2:0], line};
        end
    end

    rx_crc16_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (crc_clear),
        .bit_en (crc_en),
        .bit_in (line),
        .crc    (crc_value)
    );

    // Output registers: updated together at the stop-bit sample, so the
    // packet, flags and rx_valid all appear in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid    <= 1'b0;
            rx_packet   <= '0;
            crc_error   <= 1'b0;
            sync_error  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_valid <= load_out;
            if (load_out) begin
                rx_packet   <= shreg;
                crc_error   <= (crc_value != shreg[CRC_MSB:CRC_LSB]);
                sync_error  <= (shreg[SYNC_MSB:SYNC_LSB] != SYNC_BYTE);
                frame_error <= ~line;
            end
        end
    end

endmodule

// File: tb/tb_rx_receiver.sv
// Bench for rx_receiver: directed frames, expected responses queued at
// stimulus time and checked by an independent rx_valid monitor.
module tb_rx_receiver;

    localparam int CPB = 50;

    logic         clk;
    logic         rst_n;
    logic         rx_line;
    logic [135:0] rx_packet;
    logic         rx_valid;
    logic         crc_error;
    logic         sync_error;
    logic         frame_error;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    // {packet, crc_error, sync_error, frame_error}
    logic [138:0] exp_q[$];

    rx_receiver #(
        .CLKS_PER_BIT (CPB),
        .PKT_BITS     (136),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_line     (rx_line),
        .rx_packet   (rx_packet),
        .rx_valid    (rx_valid),
        .crc_error   (crc_error),
        .sync_error  (sync_error),
        .frame_error (frame_error),
        .busy        (busy)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference CRC-16-CCITT over v[msb:lsb], MSB first.
    function automatic logic [15:0] crc_bits(input logic [135:0] v, input int msb, input int lsb);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = msb; i >= lsb; i--) begin
            fb = c[15] ^ v[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic logic [135:0] build(input logic [7:0] s, input logic [7:0] m, input logic [103:0] d);
        logic [135:0] p;
        p = {s, m, d, 16'h0000};
        p[15:0] = crc_bits(p, 127, 16);
        return p;
    endfunction

    // Driver tasks (inputs change on the falling edge)
    task automatic drive_bit(input logic b);
        rx_line = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    // Sends start, 136 bits MSB first, and the stop bit; the line is left at
    // stop_val. A non-negative abort_bit pulses reset at that bit instead.
    task automatic send_frame(input logic [135:0] p, input logic stop_val, input int abort_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 136; i++) begin
            if (i == abort_bit) begin
                rst_n   = 1'b0;
                rx_line = 1'b1;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            drive_bit(p[135 - i]);
        end
        drive_bit(stop_val);
    endtask

    task automatic expect_frame(input logic [135:0] p, input logic c, input logic s, input logic f);
        exp_q.push_back({p, c, s, f});
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4 * CPB && exp_q.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected frame(s) never reported, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_packet"}, rx_packet, 136'h0);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_crc_error"}, crc_error, 0);
        chk({tag, "_sync_error"}, sync_error, 0);
        chk({tag, "_frame_error"}, frame_error, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [138:0] e;
        if (rst_n && rx_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: rx_valid=1 packet=%h, required no strobe", rx_packet);
            end else begin
                e = exp_q.pop_front();
                chk("rx_packet", rx_packet, e[138:3]);
                chk("crc_error", crc_error, e[2]);
                chk("sync_error", sync_error, e[1]);
                chk("frame_error", frame_error, e[0]);
            end
        end
    end

    // Stimulus
    initial begin
        logic [135:0] p1, p2, p3, p4, p5, p6, p7, p8, ref_v;
        logic [103:0] data_a, data_b;
        logic         busy_seen_low;

        data_a = 104'h0123_4567_89AB_CDEF_FEDC_BA98_76;
        data_b = 104'hDEAD_BEEF_0000_FFFF_1234_5678_9A;

        rst_n   = 1'b0;
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Reference model sanity: "123456789" gives 29B1.
        ref_v = '0;
        ref_v[71:0] = 72'h31_32_33_34_35_36_37_38_39;
        chk("crc_model_check", crc_bits(ref_v, 71, 0), 136'h29B1);

        // 1: golden frame
        p1 = build(8'hA5, 8'h01, 104'h0);
        expect_frame(p1, 1'b0, 1'b0, 1'b0);
        send_frame(p1, 1'b1, -1);
        idle_bits(2);
        wait_drain("golden_drain");
        chk("golden_busy_after", busy, 0);

        // 2: packet bit 40 flipped on the line
        p2 = p1 ^ (136'h1 << 40);
        expect_frame(p2, 1'b1, 1'b0, 1'b0);
        send_frame(p2, 1'b1, -1);
        idle_bits(2);
        wait_drain("crc_bad_drain");

        // 3: wrong sync byte, valid CRC
        p3 = build(8'h5A, 8'h02, data_a);
        expect_frame(p3, 1'b0, 1'b1, 1'b0);
        send_frame(p3, 1'b1, -1);
        idle_bits(2);
        wait_drain("sync_bad_drain");

        // 4: 10-clock glitch, then a good frame
        rx_line = 1'b0;
        repeat (10) @(negedge clk);
        rx_line = 1'b1;
        chk("glitch_busy_high", busy, 1);
        busy_seen_low = 1'b0;
        for (int i = 0; i < CPB / 2 + 3 && !busy_seen_low; i++) begin
            @(negedge clk);
            if (!busy) busy_seen_low = 1'b1;
        end
        chk("glitch_busy_released", busy_seen_low, 1);
        idle_bits(2);
        p4 = build(8'hA5, 8'h03, data_b);
        expect_frame(p4, 1'b0, 1'b0, 1'b0);
        send_frame(p4, 1'b1, -1);
        idle_bits(2);
        wait_drain("after_glitch_drain");

        // 5: stop bit low, line stuck low 500 clocks, then released
        p5 = build(8'hA5, 8'h01, data_a);
        expect_frame(p5, 1'b0, 1'b0, 1'b1);
        send_frame(p5, 1'b0, -1);
        repeat (500) @(negedge clk);
        chk("stuck_low_busy", busy, 0);
        rx_line = 1'b1;
        idle_bits(3);
        wait_drain("frame_err_drain");
        chk("frame_error_held", frame_error, 1);
        p6 = build(8'hA5, 8'h02, data_b ^ data_a);
        expect_frame(p6, 1'b0, 1'b0, 1'b0);
        send_frame(p6, 1'b1, -1);
        idle_bits(2);
        wait_drain("frame_err_clear_drain");

        // 6: reset mid-frame at bit 70, then a clean frame
        p7 = build(8'hA5, 8'h03, data_a);
        send_frame(p7, 1'b1, 70);
        @(negedge clk);
        check_reset_outputs("midreset");
        idle_bits(2);
        chk("midreset_no_valid", exp_q.size(), 0);
        p8 = build(8'hA5, 8'h01, data_b);
        expect_frame(p8, 1'b0, 1'b0, 1'b0);
        send_frame(p8, 1'b1, -1);
        idle_bits(2);
        wait_drain("post_reset_drain");
        chk("final_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
